// File: rtl/scanchain_write_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ scan-chain write requesters into one
// registered write port, holding each captured transaction until downstream accepts it.
module scanchain_write_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_BITS    = 12,
  parameter int PAYLOAD_BITS = 169,
  localparam int ID_BITS     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_BITS-1:0]    req_addr,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_payload,
  input  logic [NUM_REQ-1:0]              req_reset,
  output logic                            write_valid,
  input  logic                            write_ready,
  output logic [ADDR_BITS-1:0]            write_addr,
  output logic [PAYLOAD_BITS-1:0]         write_payload,
  output logic                            write_reset,
  output logic [ID_BITS-1:0]              grant_id,
  output logic                            busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                  state;
  state_t                  next_state;
  logic [ID_BITS-1:0]      rr_ptr;
  logic [ID_BITS-1:0]      sel;
  logic                    any_valid;
  logic                    capture;
  logic                    done_xfer;
  logic [ADDR_BITS-1:0]    sel_addr;
  logic [PAYLOAD_BITS-1:0] sel_payload;
  logic                    sel_reset;

  // Walk candidates from farthest to nearest so the nearest valid one (starting at rr_ptr) wins.
  always_comb begin : pick_requester
    int                 idx;
    logic [ID_BITS-1:0] cand;
    sel       = '0;
    any_valid = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_BITS'(idx);
      if (req_valid[cand]) begin
        sel       = cand;
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr    = '0;
    sel_payload = '0;
    sel_reset   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == ID_BITS'(i)) begin
        sel_addr    = req_addr[i*ADDR_BITS +: ADDR_BITS];
        sel_payload = req_payload[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        sel_reset   = req_reset[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = '0;
    capture    = 1'b0;
    done_xfer  = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          req_ready[sel] = 1'b1;
          capture        = 1'b1;
          next_state     = HOLD;
        end
      end
      HOLD: begin
        if (write_valid && write_ready) begin
          done_xfer  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Captured fields and grant_id persist after the transfer; only write_valid drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr        <= '0;
      write_valid   <= 1'b0;
      write_addr    <= '0;
      write_payload <= '0;
      write_reset   <= 1'b0;
      grant_id      <= '0;
    end else if (capture) begin
      write_valid   <= 1'b1;
      write_addr    <= sel_addr;
      write_payload <= sel_payload;
      write_reset   <= sel_reset;
      grant_id      <= sel;
    end else if (done_xfer) begin
      write_valid <= 1'b0;
      if (grant_id == ID_BITS'(NUM_REQ - 1)) rr_ptr <= '0;
      else                                   rr_ptr <= grant_id + 1'b1;
    end
  end

  assign busy = (state == HOLD);

endmodule

// File: tb/tb_scanchain_write_arbiter.sv
// Bench for scanchain_write_arbiter: table vectors, hand-written corner sequences,
// and randomized traffic checked against a round-robin reference model.
module tb_scanchain_write_arbiter;

  localparam int AB = 12;
  localparam int PB = 169;
  localparam logic [PB-1:0] PAY0 = 169'h1111;
  localparam logic [PB-1:0] PAY1 = 169'hDEAD;

  logic          clk;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2*AB-1:0] req_addr;
  logic [2*PB-1:0] req_payload;
  logic [1:0]    req_reset;
  logic          write_valid;
  logic          write_ready;
  logic [AB-1:0] write_addr;
  logic [PB-1:0] write_payload;
  logic          write_reset;
  logic [0:0]    grant_id;
  logic          busy;

  logic [3:0]    r4_valid;
  logic [3:0]    r4_ready;
  logic [4*AB-1:0] r4_addr;
  logic [4*PB-1:0] r4_payload;
  logic [3:0]    r4_reset;
  logic          w4_valid;
  logic          w4_ready;
  logic [AB-1:0] w4_addr;
  logic [PB-1:0] w4_payload;
  logic          w4_reset;
  logic [1:0]    g4;
  logic          b4;

  int n_checks = 0;
  int n_fail   = 0;

  scanchain_write_arbiter #(.NUM_REQ(2), .ADDR_BITS(AB), .PAYLOAD_BITS(PB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_payload(req_payload), .req_reset(req_reset),
    .write_valid(write_valid), .write_ready(write_ready), .write_addr(write_addr),
    .write_payload(write_payload), .write_reset(write_reset),
    .grant_id(grant_id), .busy(busy)
  );

  scanchain_write_arbiter #(.NUM_REQ(4), .ADDR_BITS(AB), .PAYLOAD_BITS(PB)) dut4 (
    .clk(clk), .reset(reset),
    .req_valid(r4_valid), .req_ready(r4_ready), .req_addr(r4_addr),
    .req_payload(r4_payload), .req_reset(r4_reset),
    .write_valid(w4_valid), .write_ready(w4_ready), .write_addr(w4_addr),
    .write_payload(w4_payload), .write_reset(w4_reset),
    .grant_id(g4), .busy(b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    rv;
    logic          wr;
    logic [1:0]    rdy;
    logic          wv;
    logic          gid;
    logic [AB-1:0] waddr;
    logic          wrst;
  } vec_t;

  vec_t vecs[12];

  // Reference model state
  bit            m_hold;
  int            m_rr;
  int            m_gid;
  logic [AB-1:0] m_addr;
  logic [PB-1:0] m_pay;
  logic          m_rst;

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive new inputs just after a rising edge, then return at the falling edge for checking.
  task automatic apply_stimulus(input logic [1:0] rv, input logic wr);
    @(posedge clk);
    #1;
    req_valid   = rv;
    write_ready = wr;
    @(negedge clk);
  endtask

  function automatic int pick(input logic [3:0] rv, input int n, input int rr);
    for (int k = 0; k < n; k++) begin
      if (rv[(rr + k) % n]) return (rr + k) % n;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0; write_ready = 1'b0;
    r4_valid = '0; w4_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0]    exp_rdy;
    logic [191:0]  tmp;
    int            s;

    reset       = 1'b1;
    req_valid   = '0;
    write_ready = 1'b0;
    req_addr    = {12'h0A5, 12'h100};
    req_payload = {PAY1, PAY0};
    req_reset   = 2'b10;
    r4_valid    = '0;
    w4_ready    = 1'b0;
    r4_addr     = {12'h333, 12'h222, 12'h111, 12'h000};
    r4_payload  = '0;
    r4_reset    = '0;

    #12;
    check_output("reset_write_valid", write_valid, 1'b0);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_grant_id", grant_id, 1'b0);
    check_output("reset_write_addr", write_addr, '0);
    check_output("reset_write_payload", write_payload, '0);
    check_output("reset_write_reset", write_reset, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    //                rv     wr    rdy    wv    gid   waddr    wrst
    vecs[0]  = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 12'h000, 1'b0};
    vecs[1]  = '{2'b10, 1'b1, 2'b10, 1'b0, 1'b0, 12'h000, 1'b0};
    vecs[2]  = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 12'h0A5, 1'b1};
    vecs[3]  = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 12'h0A5, 1'b1};
    vecs[4]  = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b1, 12'h0A5, 1'b1};
    vecs[5]  = '{2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 12'h100, 1'b0};
    vecs[6]  = '{2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 12'h100, 1'b0};
    vecs[7]  = '{2'b11, 1'b1, 2'b10, 1'b0, 1'b0, 12'h100, 1'b0};
    vecs[8]  = '{2'b01, 1'b0, 2'b00, 1'b1, 1'b1, 12'h0A5, 1'b1};
    vecs[9]  = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 12'h0A5, 1'b1};
    vecs[10] = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 12'h0A5, 1'b1};
    vecs[11] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 12'h0A5, 1'b1};

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].rv, vecs[i].wr);
      check_output($sformatf("vec%0d_req_ready", i), req_ready, vecs[i].rdy);
      check_output($sformatf("vec%0d_write_valid", i), write_valid, vecs[i].wv);
      check_output($sformatf("vec%0d_busy", i), busy, vecs[i].wv);
      check_output($sformatf("vec%0d_grant_id", i), grant_id, vecs[i].gid);
      check_output($sformatf("vec%0d_write_addr", i), write_addr, vecs[i].waddr);
      check_output($sformatf("vec%0d_write_reset", i), write_reset, vecs[i].wrst);
      if (vecs[i].wv)
        check_output($sformatf("vec%0d_write_payload", i), write_payload, vecs[i].gid ? PAY1 : PAY0);
    end

    // Backpressure: requester 0 held for 10 cycles while requester 1 waits
    apply_stimulus(2'b11, 1'b0);
    check_output("bp_first_ready", req_ready, 2'b01);
    for (int c = 0; c < 10; c++) begin
      apply_stimulus(2'b11, 1'b0);
      check_output($sformatf("bp%0d_write_valid", c), write_valid, 1'b1);
      check_output($sformatf("bp%0d_grant_id", c), grant_id, 1'b0);
      check_output($sformatf("bp%0d_write_addr", c), write_addr, 12'h100);
      check_output($sformatf("bp%0d_req_ready", c), req_ready, 2'b00);
    end
    apply_stimulus(2'b11, 1'b1);
    check_output("bp_accept_valid", write_valid, 1'b1);
    apply_stimulus(2'b11, 1'b0);
    check_output("bp_after_valid", write_valid, 1'b0);
    check_output("bp_next_ready", req_ready, 2'b10);
    apply_stimulus(2'b00, 1'b1);
    check_output("bp_next_grant", grant_id, 1'b1);
    check_output("bp_next_valid", write_valid, 1'b1);
    apply_stimulus(2'b00, 1'b1);
    check_output("bp_drain_valid", write_valid, 1'b0);

    // Asynchronous reset between edges while holding a transaction
    apply_stimulus(2'b01, 1'b0);
    check_output("ar_ready", req_ready, 2'b01);
    apply_stimulus(2'b00, 1'b0);
    check_output("ar_hold_valid", write_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_output("ar_write_valid", write_valid, 1'b0);
    check_output("ar_busy", busy, 1'b0);
    check_output("ar_write_addr", write_addr, '0);
    check_output("ar_grant_id", grant_id, 1'b0);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      apply_stimulus(2'b00, 1'b1);
      check_output($sformatf("ar_post%0d_valid", c), write_valid, 1'b0);
      check_output($sformatf("ar_post%0d_payload", c), write_payload, '0);
      check_output($sformatf("ar_post%0d_ready", c), req_ready, 2'b00);
    end

    // Round robin with both requesters continuously valid
    for (int c = 0; c < 17; c++) begin
      apply_stimulus(2'b11, 1'b1);
      check_output($sformatf("rr%0d_write_valid", c), write_valid, c % 2);
      if (c % 2 == 1)
        check_output($sformatf("rr%0d_grant_id", c), grant_id, ((c - 1) / 2) % 2);
    end
    apply_stimulus(2'b00, 1'b1);
    apply_stimulus(2'b00, 1'b1);

    // NUM_REQ=4 wrap behaviour
    do_reset();
    @(posedge clk); #1; r4_valid = 4'b1000; w4_ready = 1'b1;
    @(negedge clk); check_output("w4_ready_3", r4_ready, 4'b1000);
    @(posedge clk); #1; r4_valid = 4'b0000;
    @(negedge clk); check_output("w4_grant_3", g4, 2'd3);
    check_output("w4_valid_3", w4_valid, 1'b1);
    @(posedge clk); #1; r4_valid = 4'b1001;
    @(negedge clk); check_output("w4_ready_wrap", r4_ready, 4'b0001);
    @(posedge clk); #1; r4_valid = 4'b0000;
    @(negedge clk); check_output("w4_grant_0", g4, 2'd0);
    @(posedge clk); #1; r4_valid = 4'b1001;
    @(negedge clk); check_output("w4_ready_after0", r4_ready, 4'b1000);
    @(posedge clk); #1; r4_valid = 4'b0000;
    @(negedge clk); check_output("w4_grant_3b", g4, 2'd3);
    check_output("w4_addr_3b", w4_addr, 12'h333);

    // Randomized traffic against the reference model
    do_reset();
    m_hold = 0; m_rr = 0; m_gid = 0; m_addr = '0; m_pay = '0; m_rst = 1'b0;
    for (int it = 0; it < 400; it++) begin
      @(posedge clk);
      if (!m_hold) begin
        s = pick({2'b00, req_valid}, 2, m_rr);
        if (s >= 0) begin
          m_hold = 1;
          m_gid  = s;
          m_addr = req_addr[s*AB +: AB];
          m_pay  = req_payload[s*PB +: PB];
          m_rst  = req_reset[s];
        end
      end else if (write_ready) begin
        m_hold = 0;
        m_rr   = (m_gid + 1) % 2;
      end
      #1;
      req_valid   = 2'($urandom_range(0, 3));
      write_ready = ($urandom_range(0, 2) != 0);
      req_addr    = {12'($urandom), 12'($urandom)};
      tmp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      req_payload[PB-1:0] = tmp[PB-1:0];
      tmp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      req_payload[2*PB-1:PB] = tmp[PB-1:0];
      req_reset   = 2'($urandom_range(0, 3));
      @(negedge clk);
      exp_rdy = 2'b00;
      if (!m_hold) begin
        s = pick({2'b00, req_valid}, 2, m_rr);
        if (s >= 0) exp_rdy[s] = 1'b1;
      end
      check_output("rnd_req_ready", req_ready, exp_rdy);
      check_output("rnd_write_valid", write_valid, m_hold);
      check_output("rnd_busy", busy, m_hold);
      check_output("rnd_grant_id", grant_id, m_gid);
      check_output("rnd_write_addr", write_addr, m_addr);
      check_output("rnd_write_payload", write_payload, m_pay);
      check_output("rnd_write_reset", write_reset, m_rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
